// File: rtl/crc32_frame_checker.sv
// Streaming CRC-32 (IEEE 802.3, reflected) frame checker.
// Accumulates a frame, including its FCS, and reports the residue check, the runt flag and the length.
module crc32_frame_checker #(
    parameter int MIN_LEN = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        din_last,
    input  logic        din_abort,
    output logic        din_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_ok,
    output logic        res_runt,
    output logic [15:0] res_len,
    output logic [31:0] crc_run
);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [16:0] MIN_LEN_W   = 17'(MIN_LEN);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESULT} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_crc;
    logic [15:0] r_len;
    logic        r_res_ok;
    logic        r_res_runt;
    logic [15:0] r_res_len;

    logic        w_din_ready;
    logic        w_res_valid;
    logic        w_accept;
    logic [31:0] w_crc_base;
    logic [31:0] w_crc_upd;
    logic [15:0] w_len_upd;
    logic        w_len_ok;

    // Eight unrolled LSB-first shift steps: one byte per cycle.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
        end
        return v;
    endfunction

    // Abort wins over a simultaneously offered byte, in both IDLE and ACCUM.
    assign w_accept   = din_valid && w_din_ready && !din_abort;
    assign w_crc_base = (r_state == S_IDLE) ? CRC_INIT : r_crc;
    assign w_crc_upd  = crc_byte(w_crc_base, din);
    assign w_len_upd  = (r_state == S_IDLE)  ? 16'd1 :
                        (r_len == 16'hFFFF)  ? r_len : r_len + 16'd1;
    assign w_len_ok   = {1'b0, w_len_upd} >= MIN_LEN_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = din_last ? S_RESULT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (din_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_accept && din_last) begin
                    w_state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_din_ready = 1'b1;
        w_res_valid = 1'b0;
        if (r_state == S_RESULT) begin
            w_din_ready = 1'b0;
            w_res_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc      <= CRC_INIT;
            r_len      <= 16'h0;
            r_res_ok   <= 1'b0;
            r_res_runt <= 1'b0;
            r_res_len  <= 16'h0;
        end else begin
            if (r_state == S_ACCUM && din_abort) begin
                r_crc <= CRC_INIT;
                r_len <= 16'h0;
            end else if (w_accept) begin
                r_crc <= w_crc_upd;
                r_len <= w_len_upd;
                if (din_last) begin
                    r_res_ok   <= (w_crc_upd == CRC_RESIDUE) && w_len_ok;
                    r_res_runt <= !w_len_ok;
                    r_res_len  <= w_len_upd;
                end
            end else if (r_state == S_RESULT && res_ready) begin
                r_crc <= CRC_INIT;
                r_len <= 16'h0;
            end
        end
    end

    assign din_ready = w_din_ready;
    assign res_valid = w_res_valid;
    assign res_ok    = r_res_ok;
    assign res_runt  = r_res_runt;
    assign res_len   = r_res_len;
    assign crc_run   = r_crc ^ CRC_INIT;

endmodule

// File: doc/crc32_frame_checker.md
CRC32_FRAME_CHECKER -- requirements
Module: crc32_frame_checker

Interface
REQ-001 Parameter: MIN_LEN, default 5, minimum legal frame length in bytes including the 4-byte FCS.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 din  input  8  received byte, frame payload followed by FCS, each byte LSB-first in CRC order.
REQ-005 din_valid  input  1  din is valid this cycle.
REQ-006 din_last  input  1  qualifies din as the final byte of the frame, i.e. the last FCS byte.
REQ-007 din_abort  input  1  discard the current frame; sampled every cycle regardless of din_valid.
REQ-008 din_ready  output  1  checker accepts a byte this cycle; a byte transfers when din_valid and din_ready are both high.
REQ-009 res_valid  output  1  frame result available.
REQ-010 res_ready  input  1  consumer accepts the result; a result transfers when res_valid and res_ready are both high.
REQ-011 res_ok  output  1  result: CRC residue correct and length >= MIN_LEN.
REQ-012 res_runt  output  1  result: frame shorter than MIN_LEN bytes.
REQ-013 res_len  output  16  byte count of the frame including the FCS; saturates at 0xFFFF.
REQ-014 crc_run  output  32  running CRC, equal to the register XORed with 0xFFFFFFFF; valid in all states.

Function
REQ-015 CRC algorithm: CRC-32 IEEE 802.3, reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, one byte per accepted transfer.
REQ-016 Byte update: a single-cycle combinational function of the register and din, applied at the accepting clock edge.
REQ-017 States are IDLE, ACCUM and RESULT; reset enters IDLE.
REQ-018 Behaviour in IDLE:
  - din_ready=1.
  - On an accepted byte, the CRC register is updated from init 0xFFFFFFFF (not from its held value) and len is set to 1.
  - If din_last is also high, go to RESULT; otherwise go to ACCUM.
REQ-019 Behaviour in ACCUM:
  - din_ready=1.
  - Each accepted byte updates the CRC register and increments len, with saturation.
  - An accepted byte with din_last high goes to RESULT in the same edge.
REQ-020 Behaviour in RESULT:
  - din_ready=0 and res_valid=1.
  - res_ok, res_runt and res_len stay stable until the result transfers.
  - When the result transfers, go to IDLE and reload the CRC register with 0xFFFFFFFF.
REQ-021 Result evaluation, computed from the post-update register at the din_last edge:
  - res_ok = (register == 0xDEBB20E3) AND (len >= MIN_LEN).
  - res_runt = (len < MIN_LEN).
REQ-022 Latency: res_valid rises exactly one cycle after the edge that accepts the din_last byte.
REQ-023 din_valid low in IDLE or ACCUM: no state change.
REQ-024 din_abort high in ACCUM: go to IDLE, reload the CRC register with 0xFFFFFFFF and clear len; no result is produced, even if a byte is offered in the same cycle.
REQ-025 din_abort high in IDLE: the offered byte, if any, is dropped.
REQ-026 din_abort high in RESULT: ignored; the pending result is not lost.
REQ-027 din_last with din_valid low is ignored.
REQ-028 res_ready is ignored outside RESULT.
REQ-029 Length saturation: len stops at 0xFFFF; the CRC continues to update past saturation.
REQ-030 din_ready has no combinational path from din_valid, and res_valid has no combinational path from res_ready.

Reset
REQ-031 Asynchronous assertion of rst forces, without waiting for a clock edge:
  - state IDLE;
  - CRC register 0xFFFFFFFF, so crc_run = 0x00000000;
  - len 0, res_valid 0, res_ok 0, res_runt 0, res_len 0, din_ready 1.
REQ-032 Reset mid-frame or during RESULT discards the frame and the pending result; the first transfer after deassertion starts a new frame.
REQ-033 Deassertion is synchronised by the integrator; the block requires no extra cycles after deassertion.

Verification
REQ-034 Good frame: bytes "123456789" then 26 39 F4 CB, din_last on CB, res_ready=1.
  - Before the FCS bytes, crc_run = 0xCBF43926.
  - One cycle after CB: res_valid=1, res_ok=1, res_runt=0, res_len=13.
REQ-035 Corrupt frame: the same frame with the payload '5' changed to '6' -> res_ok=0, res_runt=0, res_len=13.
REQ-036 Backpressure and abort:
  - Hold res_ready=0 for 10 cycles in RESULT while din_valid=1 and din_abort pulses -> din_ready stays 0 and the result is unchanged.
  - Raise res_ready -> the result transfers and the next frame begins in IDLE.
REQ-037 Runt frame: 4 bytes 00 00 00 00 with din_last -> res_runt=1, res_ok=0, res_len=4.
REQ-038 Mid-frame events, each followed by the REQ-034 frame:
  - Abort after 6 bytes -> no result for the aborted frame; the following frame passes with res_len=13.
  - rst asserted between clock edges after 6 bytes -> the same outcome.
REQ-039 Back-to-back frames: two REQ-034 frames with a one-cycle gap, res_ready tied high -> two results, both res_ok=1 with res_len=13, and no residue carried over.
